// File: rtl/sub_bytes_pipe_if.sv
// Valid/ready bundle for sub_bytes_pipe: input beat side and output beat side.
// master drives beats in and takes results; slave is the engine.
interface sub_bytes_pipe_if #(
  parameter int LANES = 16,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_inv;
  logic [8*LANES-1:0]   in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid,
    output in_inv,
    output in_data,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_tag
  );

  modport slave (
    input  in_valid,
    input  in_inv,
    input  in_data,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_tag
  );
endinterface

// File: rtl/sub_bytes_pipe.sv
// Elastic AES SubBytes / InvSubBytes engine, LANES bytes per beat.
// One shared GF(2^8) inverter per lane; affine maps chosen by mode.
module sub_bytes_pipe #(
  parameter int LANES  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_bytes_pipe_if.slave bus,
  output logic            busy
);
  localparam int DW = 8 * LANES;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [DW-1:0]    data;
  } beat_t;

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box needs
  function automatic logic [7:0] gf_inv(
    input logic [7:0] x
  );
    logic [7:0] x3, x7, x15;
    logic [7:0] x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl(
    input logic [7:0] b,
    input int         n
  );
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] aff_fwd(
    input logic [7:0] b
  );
    return b ^ rotl(b, 1) ^ rotl(b, 2)
             ^ rotl(b, 3) ^ rotl(b, 4)
             ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(
    input logic [7:0] s
  );
    return rotl(s, 1) ^ rotl(s, 3)
         ^ rotl(s, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox(
    input logic [7:0] b,
    input logic       inv
  );
    logic [7:0] y;
    logic [7:0] z;
    y = inv ? aff_inv(b) : b;
    z = gf_inv(y);
    return inv ? z : aff_fwd(z);
  endfunction

  logic [DW-1:0]     sub_data;
  beat_t             slot_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  beat_t             src    [STAGES];
  logic [STAGES-1:0] src_v;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sub_data[8*i +: 8] =
        sbox(bus.in_data[8*i +: 8], bus.in_inv);
    end
  end

  // ready ripples back from out_ready through every empty-or-moving slot
  always_comb begin : p_load
    logic rdy;
    rdy  = bus.out_ready;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy     = ~valid_q[k] | rdy;
      load[k] = rdy;
    end
  end

  always_comb begin
    src_v[0]       = bus.in_valid;
    src[0].tag     = bus.in_tag;
    src[0].data    = sub_data;
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = valid_q[k-1];
      src[k]   = slot_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        slot_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= src_v[k];
          if (src_v[k]) slot_q[k] <= src[k];
        end
      end
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = slot_q[STAGES-1].data;
  assign bus.out_tag   = slot_q[STAGES-1].tag;
  assign busy          = |valid_q;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Directed and random checks of sub_bytes_pipe against FIPS-197 tables.
// Covers sweep, round vector, stall, mode mix, reset and two random configs.
module tb_sub_bytes_pipe;
  typedef logic [135:0] cv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic rnd_go = 1'b0;

  localparam logic [127:0] FROW [16] = '{
    128'h637c777b_f26b6fc5_3001672b_fed7ab76,
    128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
    128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
    128'h04c723c3_1896059a_071280e2_eb27b275,
    128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
    128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
    128'hd0efaafb_434d3385_45f9027f_503c9fa8,
    128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
    128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
    128'h60814fdc_222a9088_46eeb814_de5e0bdb,
    128'he0323a0a_4906245c_c2d3ac62_9195e479,
    128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
    128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
    128'h703eb566_4803f60e_613557b9_86c11d9e,
    128'he1f89811_69d98e94_9b1e87e9_ce5528df,
    128'h8ca1890d_bfe64268_41992d0f_b054bb16
  };

  localparam logic [127:0] VEC_IN  =
    128'h082a2bbe_488de2e3_f8c6f43d_e99aa019;
  localparam logic [127:0] VEC_OUT =
    128'h30e5f1ae_525d9811_41b4bf27_1eb8e0d4;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  task automatic chk(
    input string tag,
    input cv_t   got,
    input cv_t   exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] sub_ref(
    input logic [127:0] d,
    input logic         inv
  );
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = inv ? inv_tab[d[8*i +: 8]]
                        : fwd_tab[d[8*i +: 8]];
    end
    return r;
  endfunction

  sub_bytes_pipe_if #(.LANES(16), .TAG_W(4)) a_if ();
  logic a_busy;
  sub_bytes_pipe #(
    .LANES(16), .STAGES(2), .TAG_W(4)
  ) u_a (
    .clk(clk), .rst_n(rst_n),
    .bus(a_if.slave), .busy(a_busy)
  );

  sub_bytes_pipe_if #(.LANES(1), .TAG_W(4)) b_if ();
  logic b_busy;
  sub_bytes_pipe #(
    .LANES(1), .STAGES(2), .TAG_W(4)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .bus(b_if.slave), .busy(b_busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int L = (g == 0) ? 4 : 16;
    localparam int S = (g == 0) ? 1 : 4;
    localparam int W = 8 * L;

    sub_bytes_pipe_if #(.LANES(L), .TAG_W(4)) r_if ();
    logic r_busy;
    logic done = 1'b0;
    cv_t  exp_q [$];

    sub_bytes_pipe #(
      .LANES(L), .STAGES(S), .TAG_W(4)
    ) u_r (
      .clk(clk), .rst_n(rst_n),
      .bus(r_if.slave), .busy(r_busy)
    );

    initial begin
      int sent;
      int got;
      logic fi;
      logic fo;
      logic iv;
      logic [127:0] d;
      logic [127:0] e;
      r_if.in_valid  = 1'b0;
      r_if.in_inv    = 1'b0;
      r_if.in_data   = '0;
      r_if.in_tag    = '0;
      r_if.out_ready = 1'b0;
      sent = 0;
      got  = 0;
      fi   = 1'b0;
      wait (rnd_go);
      while (got < 5000) begin
        @(negedge clk);
        if (fi) r_if.in_valid = 1'b0;
        if (!r_if.in_valid && sent < 5000 &&
            $urandom_range(3) != 0) begin
          d  = {$urandom, $urandom, $urandom, $urandom};
          iv = 1'($urandom_range(1));
          e  = sub_ref(d, iv);
          r_if.in_valid = 1'b1;
          r_if.in_inv   = iv;
          r_if.in_data  = d[W-1:0];
          r_if.in_tag   = sent[3:0];
          exp_q.push_back(cv_t'({sent[3:0], e[W-1:0]}));
          sent++;
        end
        r_if.out_ready = ($urandom_range(2) != 0);
        #1;
        fi = r_if.in_valid && r_if.in_ready;
        fo = r_if.out_valid && r_if.out_ready;
        if (fo) begin
          if (exp_q.size() == 0)
            chk("rnd_extra", cv_t'(1), cv_t'(0));
          else
            chk($sformatf("rnd%0d", g),
                cv_t'({r_if.out_tag, r_if.out_data}),
                exp_q.pop_front());
          got++;
        end
      end
      done = 1'b1;
    end
  end

  task automatic one_a(
    input  logic [127:0] d,
    input  logic         inv,
    output logic [128:0] q
  );
    @(negedge clk);
    a_if.in_valid = 1'b1;
    a_if.in_inv   = inv;
    a_if.in_data  = d;
    a_if.in_tag   = 4'h5;
    @(negedge clk);
    a_if.in_valid = 1'b0;
    q = '0;
    for (int n = 0; n < 8; n++) begin
      if (a_if.out_valid) begin
        q = {1'b1, a_if.out_data};
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [127:0] row;
    logic [128:0] q;
    logic [128:0] q2;
    logic [8:0]   jv;
    logic [7:0]   e8;
    logic [127:0] e;
    logic         fi;
    logic         fo;
    int           sent;
    int           got;

    for (int r = 0; r < 16; r++) begin
      row = FROW[r];
      for (int c = 0; c < 16; c++) begin
        fwd_tab[16*r + c] = row[127 - 8*c -: 8];
      end
    end
    for (int i = 0; i < 256; i++) begin
      inv_tab[fwd_tab[i]] = i[7:0];
    end

    a_if.in_valid = 1'b0; a_if.in_inv = 1'b0;
    a_if.in_data  = '0;   a_if.in_tag = '0;
    a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_inv = 1'b0;
    b_if.in_data  = '0;   b_if.in_tag = '0;
    b_if.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", cv_t'(a_if.out_valid), cv_t'(0));
    chk("rst_busy", cv_t'(a_busy), cv_t'(0));
    chk("rst_out_data", cv_t'(a_if.out_data), cv_t'(0));
    chk("rst_out_tag", cv_t'(a_if.out_tag), cv_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cv_t'(a_if.in_ready), cv_t'(1));

    // exhaustive sweep: beat j driven at negedge j, seen at negedge j+2
    for (int i = 0; i < 514; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        jv = 9'(i - 2);
        e8 = jv[8] ? inv_tab[jv[7:0]] : fwd_tab[jv[7:0]];
        chk("sweep",
            cv_t'({b_if.out_valid, b_if.out_tag, b_if.out_data}),
            cv_t'({1'b1, jv[3:0], e8}));
      end
      if (i < 512) begin
        jv = 9'(i);
        b_if.in_valid = 1'b1;
        b_if.in_inv   = jv[8];
        b_if.in_data  = jv[7:0];
        b_if.in_tag   = jv[3:0];
      end else begin
        b_if.in_valid = 1'b0;
      end
    end

    one_a(VEC_IN, 1'b0, q);
    chk("aes_fwd", cv_t'(q), cv_t'({1'b1, VEC_OUT}));
    one_a(q[127:0], 1'b1, q2);
    chk("aes_inv", cv_t'(q2), cv_t'({1'b1, VEC_IN}));

    // backpressure: out_ready low for the first 5 cycles
    sent = 0;
    got  = 0;
    fi   = 1'b0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      if (fi) sent++;
      a_if.in_valid  = (sent < 8);
      a_if.in_inv    = 1'b0;
      a_if.in_data   = {16{8'h10 + sent[7:0]}};
      a_if.in_tag    = sent[3:0];
      a_if.out_ready = (c >= 5);
      #1;
      if (c < 5)
        chk("bp_ready", cv_t'(a_if.in_ready), cv_t'(c < 2));
      if (c >= 2 && c < 5) begin
        e = sub_ref({16{8'h10}}, 1'b0);
        chk("bp_hold",
            cv_t'({a_if.out_valid, a_if.out_tag, a_if.out_data}),
            cv_t'({1'b1, 4'd0, e}));
      end
      fi = a_if.in_valid && a_if.in_ready;
      fo = a_if.out_valid && a_if.out_ready;
      if (fo) begin
        e = sub_ref({16{8'h10 + got[7:0]}}, 1'b0);
        chk("bp_order",
            cv_t'({a_if.out_tag, a_if.out_data}),
            cv_t'({got[3:0], e}));
        got++;
      end
    end
    chk("bp_count", cv_t'(got), cv_t'(8));
    @(negedge clk);
    a_if.in_valid  = 1'b0;
    a_if.out_ready = 1'b1;

    // alternate forward 53 and inverse ed every cycle
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = (i % 2 == 0) ? {16{8'hed}} : {16{8'h53}};
        chk("mix", cv_t'({a_if.out_valid, a_if.out_data}),
            cv_t'({1'b1, e}));
      end
      if (i < 10) begin
        a_if.in_valid = 1'b1;
        a_if.in_inv   = (i % 2 == 1);
        a_if.in_data  = (i % 2 == 1) ? {16{8'hed}} : {16{8'h53}};
        a_if.in_tag   = 4'(i);
      end else begin
        a_if.in_valid = 1'b0;
      end
    end

    // reset with two beats in flight
    @(negedge clk);
    a_if.out_ready = 1'b0;
    a_if.in_valid  = 1'b1;
    a_if.in_inv    = 1'b0;
    a_if.in_data   = {16{8'h01}};
    @(negedge clk);
    a_if.in_data   = {16{8'h02}};
    @(negedge clk);
    a_if.in_valid  = 1'b0;
    chk("pre_rst_busy", cv_t'({a_busy, a_if.out_valid}), cv_t'(2'b11));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", cv_t'(a_if.out_valid), cv_t'(0));
    chk("async_rst_busy", cv_t'(a_busy), cv_t'(0));
    a_if.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_idle", cv_t'(a_if.out_valid), cv_t'(0));
    end
    chk("post_rst_ready", cv_t'(a_if.in_ready), cv_t'(1));

    rnd_go = 1'b1;
    for (int n = 0; n < 60000; n++) begin
      if (g_rnd[0].done && g_rnd[1].done) break;
      @(negedge clk);
    end
    chk("rnd_done", cv_t'({g_rnd[0].done, g_rnd[1].done}),
        cv_t'(2'b11));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
